// File: rtl/shift_latch_pkg.sv
// -----------------------------------------------------------------------------
// shift_latch_pkg
//   Types shared by the serial-to-latch control blocks.
//
//   state_t  : control FSM encoding (IDLE / SHIFT / LATCH)
//   is_busy  : true for the states in which a frame is in progress
// -----------------------------------------------------------------------------
package shift_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LATCH = 2'b10
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == SHIFT) || (s == LATCH);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//   Serial-in / parallel-out shift register.
//
//   Parameters
//     WIDTH     : number of bits held
//     MSB_FIRST : 1 -> shifts left, so the first bit ends in par_out[WIDTH-1]
//                 0 -> shifts right, so the first bit ends in par_out[0]
//   Ports
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset, clears par_out
//     shift_en  : shift sdi in on this edge
//     sdi       : serial data in
//     par_out   : parallel contents
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] par_out
);

  // NOTE: sequential state is always assigned with <= so every register
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_out <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        par_out <= {par_out[WIDTH-2:0], sdi};
      end else begin
        par_out <= {sdi, par_out[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_latch_ctrl.sv
// -----------------------------------------------------------------------------
// shift_latch_ctrl
//   Collects WIDTH serial bits into a shift register that directly feeds an
//   external transparent latch bank, then pulses the latch enable for one
//   cycle and keeps an internal copy of the latched frame.
//
//   Parameters
//     WIDTH     : bits per frame (2..32)
//     MSB_FIRST : 1 -> first bit lands in d_out[WIDTH-1]; 0 -> in d_out[0]
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : frame request, only looked at in IDLE
//     sdi    : serial data, sampled every edge in SHIFT
//     clr    : synchronous abort back to IDLE (beats start)
//     d_out  : shift-register contents, d bus of the external latch bank
//     en     : one-cycle latch enable
//     q_out  : held copy of the last latched frame
//     busy   : frame in progress (SHIFT or LATCH)
//     done   : one-cycle pulse, coincident with en
//
//   Timing: start sampled on edge E0, bits shifted on E1..E(WIDTH), the LATCH
//   state occupies the following cycle and q_out loads on its closing edge,
//   so en/done are high during the cycle after that edge (WIDTH+1 cycles
//   after E0). The shift register is idle by then, so d_out is stable for
//   the whole en pulse.
// -----------------------------------------------------------------------------
module shift_latch_ctrl
  import shift_latch_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  input  logic             clr,
  output logic [WIDTH-1:0] d_out,
  output logic             en,
  output logic [WIDTH-1:0] q_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             shift_en;
  logic             q_load;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .sdi      (sdi),
    .par_out  (d_out)
  );

  // State, counter and all outputs are registered; the combinational block
  // below only computes their next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      q_out   <= '0;
      en      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      en      <= q_load;
      done    <= q_load;
      busy    <= is_busy(state_nxt);
      if (q_load) begin
        q_out <= d_out;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    q_load      = 1'b0;

    if (clr) begin
      // Abort: drop the frame without touching d_out or q_out.
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // Last bit goes in on this edge; counter parks at 0 so it never
            // exceeds WIDTH-1.
            state_nxt   = LATCH;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          q_load    = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_latch_ctrl
//   Two instances share all inputs: one MSB-first, one LSB-first (WIDTH=8).
//   Inputs are driven and outputs sampled on the falling edge. The reference
//   model tracks the expected d_out / q_out of both instances as plain
//   integers built from the serial bit stream.
// -----------------------------------------------------------------------------
module tb_shift_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, sdi, clr;
  logic [7:0] m_d, m_q, l_d, l_q;
  logic       m_en, m_busy, m_done, l_en, l_busy, l_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_d_m = '0, exp_d_l = '0, exp_q_m = '0, exp_q_l = '0;

  always #5 clk = ~clk;

  shift_latch_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .sdi(sdi), .clr(clr),
    .d_out(m_d), .en(m_en), .q_out(m_q), .busy(m_busy), .done(m_done)
  );

  shift_latch_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .sdi(sdi), .clr(clr),
    .d_out(l_d), .en(l_en), .q_out(l_q), .busy(l_busy), .done(l_done)
  );

  // Add one received bit to the model: MSB-first grows from the right and
  // ends with the first bit at the top; LSB-first enters at the top and
  // drifts down so the first bit ends at bit 0.
  task automatic model_bit(input logic b);
    exp_d_m = (exp_d_m << 1) | 8'(b);
    exp_d_l = (exp_d_l >> 1) | (8'(b) << 7);
  endtask

  // One frame. Called at a falling edge with the block in IDLE.
  // seq[i] is the i-th serial bit. abort_at = k (1..9) raises clr for edge
  // E_k, 0 = no abort. noise toggles start randomly while the frame is busy.
  task automatic do_frame(input logic [7:0] seq, input int abort_at,
                          input bit noise, input string tag);
    logic live, exp_en, exp_busy;
    start = 1'b1;
    clr   = 1'b0;
    @(negedge clk);                      // after E0
    checks++;
    if (m_busy !== 1'b1 || l_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b/%b expected 1", tag, m_busy, l_busy);
    end
    start = (noise && abort_at == 0) ? 1'($urandom) : 1'b0;
    sdi   = seq[0];
    clr   = (abort_at == 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);                    // after E_k
      live = (abort_at == 0) || (k < abort_at);
      if (k <= 8 && live) model_bit(seq[k-1]);
      if (k == 9 && abort_at == 0) begin
        exp_q_m = exp_d_m;
        exp_q_l = exp_d_l;
      end
      exp_en   = (k == 9) && (abort_at == 0);
      exp_busy = (k <= 8) && live;
      checks++;
      if (m_en !== exp_en || l_en !== exp_en || m_done !== exp_en || l_done !== exp_en) begin
        errors++;
        $display("FAIL %s en_done k=%0d: got en %b/%b done %b/%b expected %b",
                 tag, k, m_en, l_en, m_done, l_done, exp_en);
      end
      checks++;
      if (m_busy !== exp_busy || l_busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b/%b expected %b", tag, k, m_busy, l_busy, exp_busy);
      end
      if (k == 9 || k == 11) begin
        checks++;
        if (m_d !== exp_d_m || l_d !== exp_d_l || m_q !== exp_q_m || l_q !== exp_q_l) begin
          errors++;
          $display("FAIL %s data k=%0d: got d %h/%h q %h/%h expected d %h/%h q %h/%h",
                   tag, k, m_d, l_d, m_q, l_q, exp_d_m, exp_d_l, exp_q_m, exp_q_l);
        end
      end
      clr   = (k + 1 == abort_at);
      sdi   = (k < 8) ? seq[k] : 1'($urandom);
      start = (noise && abort_at == 0 && k <= 8) ? 1'($urandom) : 1'b0;
    end
    clr   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sdi = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_en, m_done, m_busy, l_en, l_done, l_busy} !== 6'b0 ||
        m_d !== 8'h00 || m_q !== 8'h00 || l_d !== 8'h00 || l_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got d %h/%h q %h/%h en %b busy %b done %b expected all 0",
               m_d, l_d, m_q, l_q, m_en, m_busy, m_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sdi = 1'($urandom);
      @(negedge clk);
      checks++;
      if (m_en !== 1'b0 || l_en !== 1'b0 || m_busy !== 1'b0 || m_d !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d: got en %b/%b busy %b d %h expected 0",
                 i, m_en, l_en, m_busy, m_d);
      end
    end
  endtask

  task automatic test_single_frame();
    // sdi sequence 1,0,1,1,0,0,1,0 (seq[i] = i-th bit)
    do_frame(8'h4D, 0, 1'b0, "single");
    checks++;
    if (m_q !== 8'hB2 || l_q !== 8'h4D) begin
      errors++;
      $display("FAIL single_q: got %h/%h expected b2/4d", m_q, l_q);
    end
  endtask

  task automatic test_abort();
    do_frame(8'h4D, 5, 1'b0, "abort");
    checks++;
    if (m_q !== 8'hB2 || l_q !== 8'h4D) begin
      errors++;
      $display("FAIL abort_q_kept: got %h/%h expected b2/4d", m_q, l_q);
    end
  endtask

  task automatic test_clr_priority();
    // clr and start together in IDLE: clr wins
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    checks++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_beats_start: got busy %b/%b expected 0", m_busy, l_busy);
    end
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (m_en !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_beats_start_idle: got en %b busy %b expected 0", m_en, m_busy);
      end
    end
    // clr during the LATCH cycle suppresses the latch
    do_frame(8'h3C, 9, 1'b0, "clr_in_latch");
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_busy;
    start = 1'b1; clr = 1'b0;
    @(negedge clk);                      // after E0
    sdi = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);                    // after E_k
      exp_en   = (k == 9) || (k == 19);
      exp_busy = (k <= 8) || (k >= 10 && k <= 18);
      if (k <= 8)  model_bit(1'b1);
      if (k >= 11 && k <= 18) model_bit(1'b0);
      if (exp_en) begin
        exp_q_m = exp_d_m;
        exp_q_l = exp_d_l;
      end
      checks++;
      if (m_en !== exp_en || l_en !== exp_en || m_done !== exp_en) begin
        errors++;
        $display("FAIL b2b en k=%0d: got %b/%b done %b expected %b", k, m_en, l_en, m_done, exp_en);
      end
      checks++;
      if (m_busy !== exp_busy || l_busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b busy k=%0d: got %b/%b expected %b", k, m_busy, l_busy, exp_busy);
      end
      if (k == 9) begin
        checks++;
        if (m_q !== 8'hFF || l_q !== 8'hFF) begin
          errors++;
          $display("FAIL b2b first_q: got %h/%h expected ff", m_q, l_q);
        end
      end
      sdi = (k + 1 <= 8) ? 1'b1 : 1'b0;
      if (k == 19) start = 1'b0;
    end
    checks++;
    if (m_q !== 8'h00 || l_q !== 8'h00 || m_d !== exp_d_m || l_d !== exp_d_l) begin
      errors++;
      $display("FAIL b2b final: got q %h/%h d %h/%h expected q 00 d %h/%h",
               m_q, l_q, m_d, l_d, exp_d_m, exp_d_l);
    end
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      sdi = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    exp_d_m = '0; exp_d_l = '0; exp_q_m = '0; exp_q_l = '0;
    checks++;
    if (m_d !== 8'h00 || l_d !== 8'h00 || m_q !== 8'h00 || l_q !== 8'h00 ||
        m_busy !== 1'b0 || m_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got d %h/%h q %h/%h busy %b en %b expected 0",
               m_d, l_d, m_q, l_q, m_busy, m_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom);
      @(negedge clk);
      checks++;
      if (m_en !== 1'b0 || l_en !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_frame_idle cyc=%0d: got en %b/%b busy %b expected 0",
                 i, m_en, l_en, m_busy);
      end
    end
    do_frame(8'hA7, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] seq;
    int         abort_at;
    for (int n = 0; n < 30; n++) begin
      seq      = 8'($urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      do_frame(seq, abort_at, 1'b1, "random");
      repeat ($urandom_range(0, 3)) begin
        sdi = 1'($urandom);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_abort();
    test_clr_priority();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
